data_memory_access_unit: RTL and testbench

- MEM-stage data-memory controller, directly downstream of the EX stage register.
- Takes load/store requests (mem_read, mem_write, fun_3, address, store data) and drives a multi-cycle word-wide data memory through a req/ack handshake.
- Performs byte-lane alignment and load sign/zero extension.
- Generates the busywait that stalls the whole pipeline, i.e. data_memory_busywait at cpu level.

---
 rtl/data_memory_access_unit.sv | 219 +++++++++++++++++++++
 tb/tb_data_memory_access_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_access_unit.sv
// MEM-stage data-memory controller: req/ack handshake, byte-lane
// alignment, load extension and pipeline busywait generation.
module data_memory_access_unit #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  fun_3,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        busywait,
  output logic        misaligned,
  output logic        bus_error,
  output logic        mem_req_read,
  output logic        mem_req_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byte_en,
  input  logic [31:0] mem_readdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);

  state_e state_q, state_d;

  logic [1:0]       addr_q, addr_d;
  logic [2:0]       fun3_q, fun3_d;
  logic             wr_q, wr_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             mis_q, mis_d;
  logic             berr_q, berr_d;
  logic             req_rd_q, req_rd_d;
  logic             req_wr_q, req_wr_d;
  logic [31:0]      maddr_q, maddr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        req;
  logic        legal;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_ext;
  logic        tmo;

  assign req = mem_read | mem_write;

  // Legality of the incoming request (alignment and funct3 encoding)
  always_comb begin
    legal = 1'b0;
    case (fun_3)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~address[0];
      3'b010:  legal = (address[1:0] == 2'b00);
      3'b100:  legal = ~mem_write;
      3'b101:  legal = ~mem_write & ~address[0];
      default: legal = 1'b0;
    endcase
  end

  // Store lane replication and byte enables from the incoming request
  always_comb begin
    st_data = write_data;
    st_be   = 4'b1111;
    case (fun_3[1:0])
      2'b00: begin
        st_data = {4{write_data[7:0]}};
        st_be   = 4'b0001 << address[1:0];
      end
      2'b01: begin
        st_data = {2{write_data[15:0]}};
        st_be   = 4'b0011 << {address[1], 1'b0};
      end
      default: begin
        st_data = write_data;
        st_be   = 4'b1111;
      end
    endcase
  end

  // Load lane extraction and sign/zero extension of the memory word
  always_comb begin
    ld_b   = mem_readdata[{addr_q, 3'b000} +: 8];
    ld_h   = mem_readdata[{addr_q[1], 4'b0000} +: 16];
    ld_ext = mem_readdata;
    case (fun3_q)
      3'b000:  ld_ext = {{24{ld_b[7]}}, ld_b};
      3'b001:  ld_ext = {{16{ld_h[15]}}, ld_h};
      3'b100:  ld_ext = {24'b0, ld_b};
      3'b101:  ld_ext = {16'b0, ld_h};
      default: ld_ext = mem_readdata;
    endcase
  end

  assign tmo = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    fun3_d   = fun3_q;
    wr_d     = wr_q;
    rdata_d  = rdata_q;
    mis_d    = mis_q;
    berr_d   = berr_q;
    req_rd_d = req_rd_q;
    req_wr_d = req_wr_q;
    maddr_d  = maddr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = address[1:0];
          fun3_d  = fun_3;
          wr_d    = mem_write;
          rdata_d = '0;
          mis_d   = 1'b0;
          berr_d  = 1'b0;
          cnt_d   = '0;
          if (!legal) begin
            mis_d   = 1'b1;
            state_d = DONE;
          end else begin
            req_rd_d = ~mem_write;
            req_wr_d = mem_write;
            maddr_d  = {address[31:2], 2'b00};
            wdata_d  = st_data;
            be_d     = mem_write ? st_be : 4'b0000;
            state_d  = ACCESS;
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_ack) begin
          req_rd_d = 1'b0;
          req_wr_d = 1'b0;
          rdata_d  = wr_q ? 32'b0 : ld_ext;
          state_d  = DONE;
        end else if (tmo) begin
          req_rd_d = 1'b0;
          req_wr_d = 1'b0;
          berr_d   = 1'b1;
          rdata_d  = '0;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      fun3_q   <= '0;
      wr_q     <= 1'b0;
      rdata_q  <= '0;
      mis_q    <= 1'b0;
      berr_q   <= 1'b0;
      req_rd_q <= 1'b0;
      req_wr_q <= 1'b0;
      maddr_q  <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      fun3_q   <= fun3_d;
      wr_q     <= wr_d;
      rdata_q  <= rdata_d;
      mis_q    <= mis_d;
      berr_q   <= berr_d;
      req_rd_q <= req_rd_d;
      req_wr_q <= req_wr_d;
      maddr_q  <= maddr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busywait = ~reset &
                    ((state_q == ACCESS) ||
                     ((state_q == IDLE) && req));

  assign read_data     = rdata_q;
  assign misaligned    = mis_q;
  assign bus_error     = berr_q;
  assign mem_req_read  = req_rd_q;
  assign mem_req_write = req_wr_q;
  assign mem_address   = maddr_q;
  assign mem_writedata = wdata_q;
  assign mem_byte_en   = be_q;

endmodule

// File: tb/tb_data_memory_access_unit.sv
// Scoreboard bench for data_memory_access_unit with a small
// ack-after-N memory responder driven from the access task.
module tb_data_memory_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [2:0]  fun_3;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        busywait, misaligned, bus_error;
  logic        mem_req_read, mem_req_write;
  logic [31:0] mem_address, mem_writedata;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_readdata;
  logic        mem_ack;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        mis;
    logic        berr;
    int          busy;
    int          strobes;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  exp_t sb[$];

  data_memory_access_unit #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk),
    .reset(reset),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .fun_3(fun_3),
    .address(address),
    .write_data(write_data),
    .read_data(read_data),
    .busywait(busywait),
    .misaligned(misaligned),
    .bus_error(bus_error),
    .mem_req_read(mem_req_read),
    .mem_req_write(mem_req_write),
    .mem_address(mem_address),
    .mem_writedata(mem_writedata),
    .mem_byte_en(mem_byte_en),
    .mem_readdata(mem_readdata),
    .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input string tag,
                              input logic [31:0] rdata,
                              input logic mis, berr,
                              input int busy, strobes,
                              input logic wr,
                              input logic [31:0] addr, wdata,
                              input logic [3:0] be);
    exp_t e;
    e.tag = tag; e.rdata = rdata; e.mis = mis; e.berr = berr;
    e.busy = busy; e.strobes = strobes; e.wr = wr;
    e.addr = addr; e.wdata = wdata; e.be = be;
    return e;
  endfunction

  // Called at posedge+1 in an IDLE cycle; returns at posedge+1
  // of the cycle after DONE. ack_n: strobe cycle that gets ack
  // (0 = never).
  task automatic run(input logic rd, wr,
                     input logic [2:0] f3,
                     input logic [31:0] a, wd, mrd,
                     input int ack_n,
                     input exp_t e);
    int busy, st;
    bit done;
    logic [31:0] ga, gw, grd;
    logic [3:0]  gbe;
    logic        gwr, gm, gbr;
    exp_t x;
    sb.push_back(e);
    mem_read = rd; mem_write = wr; fun_3 = f3;
    address = a; write_data = wd; mem_readdata = mrd;
    busy = 0; st = 0; done = 0;
    ga = '0; gw = '0; gbe = '0; gwr = 1'b0;
    grd = '0; gm = 1'b0; gbr = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (mem_req_read | mem_req_write) begin
        st++;
        ga = mem_address; gw = mem_writedata;
        gbe = mem_byte_en; gwr = mem_req_write;
        if (st == ack_n) mem_ack = 1'b1;
      end
      if (busywait) busy++;
      else begin
        done = 1;
        grd = read_data; gm = misaligned; gbr = bus_error;
        mem_read = 1'b0; mem_write = 1'b0;
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
    x = sb.pop_front();
    if (!done) chk({x.tag, "_hang"}, 32'd1, 32'd0);
    chk({x.tag, "_rdata"}, grd, x.rdata);
    chk({x.tag, "_mis"}, 32'(gm), 32'(x.mis));
    chk({x.tag, "_berr"}, 32'(gbr), 32'(x.berr));
    chk({x.tag, "_busy"}, busy, x.busy);
    chk({x.tag, "_strobes"}, st, x.strobes);
    if (x.strobes > 0) begin
      chk({x.tag, "_kind"}, 32'(gwr), 32'(x.wr));
      chk({x.tag, "_maddr"}, ga, x.addr);
      chk({x.tag, "_be"}, 32'(gbe), 32'(x.be));
      if (x.wr) chk({x.tag, "_wdata"}, gw, x.wdata);
    end
  endtask

  initial begin
    reset = 1'b1;
    mem_read = 1'b1; mem_write = 1'b0; fun_3 = 3'b010;
    address = 32'h100; write_data = '0;
    mem_readdata = '0; mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busywait), 0);
    chk("rst_rdata", read_data, 0);
    chk("rst_req", 32'({mem_req_read, mem_req_write}), 0);
    chk("rst_maddr", mem_address, 0);
    chk("rst_flags", 32'({misaligned, bus_error}), 0);
    mem_read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    run(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 3,
        mk("lw", 32'hDEADBEEF, 0, 0, 4, 3, 0, 32'h100, 0, 4'b0000));
    run(1, 0, 3'b000, 32'h203, 0, 32'h80123456, 1,
        mk("lb", 32'hFFFFFF80, 0, 0, 2, 1, 0, 32'h200, 0, 4'b0000));
    run(1, 0, 3'b100, 32'h203, 0, 32'h80123456, 2,
        mk("lbu", 32'h00000080, 0, 0, 3, 2, 0, 32'h200, 0, 4'b0000));
    run(1, 0, 3'b001, 32'h202, 0, 32'h80123456, 1,
        mk("lh", 32'hFFFF8012, 0, 0, 2, 1, 0, 32'h200, 0, 4'b0000));
    run(1, 0, 3'b101, 32'h200, 0, 32'h80129876, 1,
        mk("lhu", 32'h00009876, 0, 0, 2, 1, 0, 32'h200, 0, 4'b0000));
    run(0, 1, 3'b000, 32'h1F1, 32'h000000AB, 0, 1,
        mk("sb", 0, 0, 0, 2, 1, 1, 32'h1F0, 32'hABABABAB, 4'b0010));
    run(0, 1, 3'b001, 32'h1F2, 32'h00001234, 0, 2,
        mk("sh", 0, 0, 0, 3, 2, 1, 32'h1F0, 32'h12341234, 4'b1100));
    run(1, 0, 3'b010, 32'h104, 0, 32'h0BADF00D, 1,
        mk("lw2", 32'h0BADF00D, 0, 0, 2, 1, 0, 32'h104, 0, 4'b0000));
    run(1, 0, 3'b010, 32'h102, 0, 32'h11111111, 1,
        mk("lw_mis", 0, 1, 0, 1, 0, 0, 0, 0, 4'b0000));
    run(0, 1, 3'b001, 32'h101, 32'h5555, 0, 1,
        mk("sh_mis", 0, 1, 0, 1, 0, 0, 0, 0, 4'b0000));
    run(1, 0, 3'b011, 32'h100, 0, 32'h11111111, 1,
        mk("f3_011", 0, 1, 0, 1, 0, 0, 0, 0, 4'b0000));
    run(0, 1, 3'b100, 32'h100, 32'h77, 0, 1,
        mk("sbu_ill", 0, 1, 0, 1, 0, 0, 0, 0, 4'b0000));
    run(1, 1, 3'b000, 32'h123, 32'h000000C3, 32'h99999999, 1,
        mk("rw_both", 0, 0, 0, 2, 1, 1, 32'h120, 32'hC3C3C3C3,
           4'b1000));
    run(1, 0, 3'b010, 32'h180, 0, 32'h12345678, 0,
        mk("tmo", 0, 0, 1, 5, 4, 0, 32'h180, 0, 4'b0000));
    run(1, 0, 3'b010, 32'h184, 0, 32'h12345678, 4,
        mk("tmo_ack", 32'h12345678, 0, 0, 5, 4, 0, 32'h184, 0,
           4'b0000));

    // stray ack in IDLE must not disturb held results
    mem_ack = 1'b1;
    @(negedge clk);
    chk("idle_ack_busy", 32'(busywait), 0);
    chk("idle_ack_rd", read_data, 32'h12345678);
    @(posedge clk); #1;
    mem_ack = 1'b0;

    // reset in the middle of an access
    mem_read = 1'b1; fun_3 = 3'b010; address = 32'h300;
    mem_readdata = 32'hFEEDFACE;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_strobe", 32'(mem_req_read), 1);
    @(posedge clk); #1;
    reset = 1'b1; mem_read = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busywait), 0);
    @(posedge clk); #1;
    reset = 1'b0; mem_ack = 1'b1;
    @(negedge clk);
    chk("mid_rst_req", 32'({mem_req_read, mem_req_write}), 0);
    chk("mid_rst_maddr", mem_address, 0);
    chk("mid_rst_rd", read_data, 0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    chk("post_ack_rd", read_data, 0);
    chk("post_ack_busy", 32'(busywait), 0);
    chk("post_ack_flags", 32'({misaligned, bus_error}), 0);
    @(posedge clk); #1;

    run(1, 0, 3'b010, 32'h40, 0, 32'h11223344, 1,
        mk("b2b_lw", 32'h11223344, 0, 0, 2, 1, 0, 32'h40, 0,
           4'b0000));
    run(0, 1, 3'b010, 32'h44, 32'hCAFEF00D, 0, 2,
        mk("b2b_sw", 0, 0, 0, 3, 2, 1, 32'h44, 32'hCAFEF00D,
           4'b1111));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
